// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths:
// FSM encoding, oversampling constants and the baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  // Ticks per bit; the vote taps below assume this value.
  localparam int OVERSAMPLE = 16;

  // Sub-bit tick positions: three vote taps around mid-bit and the last tick.
  localparam logic [3:0] VOTE_TAP_A = 4'd7;
  localparam logic [3:0] VOTE_TAP_B = 4'd8;
  localparam logic [3:0] VOTE_TAP_C = 4'd9;
  localparam logic [3:0] BIT_END    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversampling tick, floored; never below one.
  function automatic int baud_div(input int clock_freq, input int baud_rate,
                                  input int oversample);
    int div;
    div = clock_freq / (baud_rate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
// Shared by the receiver and transmitter.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises the line, oversamples each bit 16x,
// takes a 2-of-3 vote around mid-bit, validates start and stop bits, and
// hands completed bytes to a one-entry valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_frontend #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);

  logic        rx_meta;
  logic        rx_s;
  logic        tick;
  uart_state_e state;
  logic [3:0]  scnt;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic        vote_a;
  logic        vote_b;
  logic        vote_maj;
  logic        decide;
  logic        deliver;

  // Two-flop synchroniser; both stages reset to the idle (high) level.
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking assignments here would collapse the two stages into one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Vote result and the decision/delivery strobes for the current cycle.
  // NOTE: every signal gets a value on every pass, so no latch can form.
  always_comb begin
    vote_maj = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    decide   = tick && (scnt == VOTE_TAP_C);
    deliver  = decide && (state == ST_STOP) && vote_maj;
  end

  // Receive FSM with sub-bit/bit counters, vote taps, shift register,
  // framing-error pulse and busy flag, all registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      vote_a       <= 1'b1;
      vote_b       <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      if (tick) begin
        if (scnt == VOTE_TAP_A) vote_a <= rx_s;
        if (scnt == VOTE_TAP_B) vote_b <= rx_s;

        unique case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state   <= ST_START;
              scnt    <= '0;
              rx_busy <= 1'b1;
            end
          end

          ST_START: begin
            scnt <= scnt + 4'd1;
            if (decide && vote_maj) begin
              // Line came back high by mid start bit: a glitch, not a frame.
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end else if (scnt == BIT_END) begin
              state <= ST_DATA;
              bcnt  <= '0;
            end
          end

          ST_DATA: begin
            scnt <= scnt + 4'd1;
            if (decide) begin
              shreg <= {vote_maj, shreg[7:1]};
            end
            if (scnt == BIT_END) begin
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                state <= ST_STOP;
              end
            end
          end

          ST_STOP: begin
            scnt <= scnt + 4'd1;
            if (decide) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              state        <= vote_maj ? ST_IDLE : ST_BREAK;
              rx_busy      <= ~vote_maj;
              rx_frame_err <= ~vote_maj;
            end
          end

          ST_BREAK: begin
            // Wait for the line to return high so a held-low line cannot retrigger.
            if (rx_s) begin
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end

          default: begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-entry holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          // Empty, or being emptied this same edge: take the new byte.
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          // Consumer still holding the old byte: drop the new one.
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed self-checking bench for uart_rx_frontend.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

  localparam int  CLOCK_FREQ = 100_000_000;
  // Line rate gives an exact divisor of 8 (80 ns tick, 1280 ns bit) so every
  // frame is short in simulation while the tick/vote arithmetic is unchanged.
  localparam int  BAUD_RATE  = 781_250;
  localparam real BIT        = 1280.0;
  // Whole number of ticks (180 x 80 ns): shifting a frame start by this
  // keeps the same tick phase, so its delivery edge shifts by the same amount.
  localparam real PHASE_SHIFT = 14400.0;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         err_cycles = 0;
  int         ovr_cycles = 0;
  real        last_ovr_t = 0.0;
  real        valid_rise_t = 0.0;
  logic       valid_d = 1'b0;
  bit         log_en = 1'b0;
  logic [7:0] rx_log[$];

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  // Observe outputs mid-cycle: count pulse cycles and log new bytes.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) err_cycles++;
    if (rx_overrun === 1'b1) begin
      ovr_cycles++;
      last_ovr_t = $realtime;
    end
    if (rx_valid === 1'b1 && valid_d !== 1'b1) begin
      valid_rise_t = $realtime;
      if (log_en) rx_log.push_back(rx_data);
    end
    valid_d = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame, LSB first; the line is left at the stop level.
  task automatic send_byte(input logic [7:0] d, input logic stop_lvl, input real bit_t);
    uart_rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(bit_t);
    end
    uart_rx = stop_lvl;
    #(bit_t);
  endtask

  task automatic handshake();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    real        t0;
    real        t_hs;
    real        lat;
    int         e0;
    int         o0;
    logic [7:0] exp2 [4] = '{8'h00, 8'hFF, 8'hAA, 8'h55};
    real        tol [2]  = '{1.03, 0.97};
    logic [7:0] got;

    // Reset state
    resetn   = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_frame_err", rx_frame_err, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    // Case 1: single byte, consumer not ready, then one-clock handshake
    e0 = err_cycles;
    o0 = ovr_cycles;
    @(negedge clk);
    t0 = $realtime;
    fork
      send_byte(8'h5A, 1'b1, BIT);
      begin
        #(5.0 * BIT);
        check("t1_busy_mid", rx_busy, 1'b1);
        check("t1_valid_mid", rx_valid, 1'b0);
      end
    join
    #(BIT);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'h5A);
    lat = valid_rise_t - t0;
    check("t1_latency_in_window", (lat >= 12200.0 && lat <= 12600.0), 1'b1);
    check("t1_no_err", err_cycles - e0, 0);
    check("t1_no_ovr", ovr_cycles - o0, 0);
    handshake();
    check("t1_valid_cleared", rx_valid, 1'b0);

    // Case 2: four back-to-back frames, consumer always ready
    e0 = err_cycles;
    o0 = ovr_cycles;
    rx_log.delete();
    log_en   = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(exp2[i], 1'b1, BIT);
    #(BIT);
    log_en = 1'b0;
    check("t2_count", rx_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_log.size()) ? rx_log[i] : 8'hxx;
      check("t2_byte", got, exp2[i]);
    end
    check("t2_no_err", err_cycles - e0, 0);
    check("t2_no_ovr", ovr_cycles - o0, 0);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t2_valid_idle", rx_valid, 1'b0);

    // Case 3: overrun keeps the old byte; delivery with handshake replaces it
    e0 = err_cycles;
    o0 = ovr_cycles;
    @(negedge clk);
    send_byte(8'h33, 1'b1, BIT);
    #(BIT);
    check("t3_first_valid", rx_valid, 1'b1);
    check("t3_first_data", rx_data, 8'h33);
    @(negedge clk);
    t0 = $realtime;
    send_byte(8'hC3, 1'b1, BIT);
    #(BIT);
    check("t3_overrun_keeps_data", rx_data, 8'h33);
    check("t3_overrun_valid", rx_valid, 1'b1);
    check("t3_overrun_pulses", ovr_cycles - o0, 1);
    t_hs = last_ovr_t + PHASE_SHIFT;
    #(t0 + PHASE_SHIFT - $realtime);
    fork
      send_byte(8'h96, 1'b1, BIT);
      begin
        #(t_hs - 12.0 - $realtime);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t3_same_cycle_valid", rx_valid, 1'b1);
        check("t3_same_cycle_data", rx_data, 8'h96);
      end
    join
    #(BIT);
    check("t3_same_cycle_no_ovr", ovr_cycles - o0, 1);
    check("t3_no_err", err_cycles - e0, 0);
    check("t3_data_held", rx_data, 8'h96);
    handshake();
    check("t3_valid_cleared", rx_valid, 1'b0);

    // Case 4: low stop bit then held-low line, then recovery
    e0 = err_cycles;
    o0 = ovr_cycles;
    @(negedge clk);
    send_byte(8'hA5, 1'b0, BIT);
    #(3.0 * BIT);
    check("t4_frame_err_once", err_cycles - e0, 1);
    check("t4_no_valid", rx_valid, 1'b0);
    check("t4_break_busy", rx_busy, 1'b1);
    check("t4_no_ovr", ovr_cycles - o0, 0);
    uart_rx = 1'b1;
    #(BIT / 2.0);
    check("t4_break_exit", rx_busy, 1'b0);
    @(negedge clk);
    send_byte(8'h11, 1'b1, BIT);
    #(BIT);
    check("t4_recover_valid", rx_valid, 1'b1);
    check("t4_recover_data", rx_data, 8'h11);
    check("t4_recover_no_err", err_cycles - e0, 1);
    handshake();

    // Case 5: short low glitch on an idle line is rejected as a false start
    e0 = err_cycles;
    o0 = ovr_cycles;
    @(negedge clk);
    uart_rx = 1'b0;
    #300;
    check("t5_busy_on_glitch", rx_busy, 1'b1);
    #148;
    uart_rx = 1'b1;
    #(BIT - 448.0);
    check("t5_busy_dropped", rx_busy, 1'b0);
    #(BIT);
    check("t5_no_valid", rx_valid, 1'b0);
    check("t5_no_err", err_cycles - e0, 0);
    check("t5_no_ovr", ovr_cycles - o0, 0);

    // Case 6: asynchronous reset during bit 4 of a frame
    check("t6_pre_reset_data", rx_data, 8'h11);
    @(negedge clk);
    fork
      send_byte(8'h7E, 1'b1, BIT);
      begin
        #(5.5 * BIT - 1.0);
        check("t6_busy_before_reset", rx_busy, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_valid", rx_valid, 1'b0);
        check("t6_rst_busy", rx_busy, 1'b0);
        check("t6_rst_frame_err", rx_frame_err, 1'b0);
        check("t6_rst_overrun", rx_overrun, 1'b0);
      end
    join
    #(BIT);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_idle_after_release", rx_busy, 1'b0);
    @(negedge clk);
    send_byte(8'h42, 1'b1, BIT);
    #(BIT);
    check("t6_after_reset_valid", rx_valid, 1'b1);
    check("t6_after_reset_data", rx_data, 8'h42);
    handshake();

    // Baud tolerance: sender +3% and -3% bit period
    for (int k = 0; k < 2; k++) begin
      e0 = err_cycles;
      @(negedge clk);
      send_byte(8'h5A, 1'b1, BIT * tol[k]);
      #(BIT);
      check((k == 0) ? "tol_slow_valid" : "tol_fast_valid", rx_valid, 1'b1);
      check((k == 0) ? "tol_slow_data" : "tol_fast_data", rx_data, 8'h5A);
      check((k == 0) ? "tol_slow_no_err" : "tol_fast_no_err", err_cycles - e0, 0);
      handshake();
      check((k == 0) ? "tol_slow_cleared" : "tol_fast_cleared", rx_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

UART receive front end that deserialises the `uart_rx` pin into bytes for `axi_uart_bridge`, sitting directly upstream of its RXDATA/STATUS registers. It uses 16x oversampling with majority-vote bit sampling, rejects false starts, detects framing errors, and presents each byte on a one-entry valid/ready holding register. Overrun and framing errors are reported as one-cycle pulses, which the bridge may latch into STATUS.

## Interface
- `CLOCK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; other values are unsupported.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial line, asynchronous to `clk`, idles high.
- `rx_data` out 8: received byte, stable while `rx_valid`=1.
- `rx_valid` out 1: byte available.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid`&&`rx_ready` at a rising edge.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `rx_overrun` out 1: one-cycle pulse when a completed byte is dropped.
- `rx_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Input is synchronised by 2 flops, both reset to 1, giving `rx_s`.
- Tick generator: free-running counter 0..DIV-1, where DIV = CLOCK_FREQ/(BAUD_RATE*16) using integer floor (54 at the defaults). `tick` is 1 clock wide when the counter is at DIV-1.
- `scnt`: 4-bit count of ticks within a bit, wrapping 15→0. `bcnt`: 3-bit data-bit index.
- Majority vote: `rx_s` is sampled on the ticks where `scnt` = 7, 8 and 9. The bit value is the 2-of-3 majority, decided on the `scnt`=9 tick.
- FSM states are IDLE, START, DATA, STOP and BREAK.
  - IDLE: on a tick with `rx_s`=0, go to START with `scnt`=0.
  - START: at the decision point, a majority of 1 is a false start; return to IDLE with no outputs. A majority of 0 means: continue to the `scnt`=15 tick, then go to DATA with `bcnt`=0.
  - DATA: at each decision, shift the bit into a shift register, LSB first. At the `scnt`=15 tick, increment `bcnt`. After bit 7, go to STOP.
  - STOP: at the decision point, a majority of 1 delivers the byte to the holding register and goes to IDLE immediately, at mid stop bit. A majority of 0 pulses `rx_frame_err`, discards the byte and goes to BREAK.
  - BREAK: go to IDLE on the first tick with `rx_s`=1. This prevents a held-low line from retriggering reception.
- Holding register:
  - A delivered byte with `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - `rx_valid`&&`rx_ready` with no delivery that cycle: clear `rx_valid`.
  - Delivery and handshake in the same cycle: load the new byte, keep `rx_valid`=1, no overrun.
  - Delivery while `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, pulse `rx_overrun`.
- Reset, asynchronous and possible mid-frame:
  - FSM returns to IDLE; all counters and the shift register clear.
  - `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.
  - After release, a frame already in progress is not resumed. A low data bit seen in IDLE is treated as a start and is filtered by START validation or a later framing error.

## Timing
- Start detection lags the pin edge by 2 synchroniser clocks plus up to 1 tick (≤1/16 bit of phase error).
- `rx_valid` and `rx_data` update on the clock after the stop-bit decision tick, about 9.6 bit periods after the start edge (about 83 µs at the defaults).
- `rx_frame_err` and `rx_overrun` are registered and high for exactly 1 clock, in the same cycle a valid byte would have appeared.
- `rx_busy` rises the clock after start detection and falls with the IDLE transition.
- Baud-rate tolerance is ±3% between sender and receiver.
- Back-to-back frames with zero idle time must be received without loss.
- `rx_valid` remains asserted until the handshake completes, with no timeout.

## Structure
- Shared package `uart_pkg`, also used by the TX side:
  - FSM state encodings.
  - `OVERSAMPLE`=16.
  - Constants for the vote taps (7/8/9) and end of bit (15).
  - A function computing DIV from CLOCK_FREQ and BAUD_RATE.
- Sub-module `uart_baud_tick`: parameterised divisor producing the `tick` pulse. It is reusable by the transmitter.

## Test plan
Defaults throughout: 100 MHz clock, 8680.6 ns bit period.
1. Send 0x5A with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0x5A about 83 µs after the start edge. Raise `rx_ready` for 1 clock → `rx_valid`=0 the next clock.
2. Send 0x00, 0xFF, 0xAA, 0x55 back-to-back with no idle and `rx_ready` held 1 → four deliveries, in order and exact, with no error pulses.
3. Send 0x33, then 0xC3 while `rx_ready`=0 → `rx_data` stays 0x33 and `rx_overrun` pulses once. Then send 0x96 completing in the same clock as a handshake → `rx_data`=0x96, `rx_valid` stays 1, no overrun.
4. Send 0xA5 with the stop bit forced low, then hold the line low for 3 bits → one `rx_frame_err` pulse, no `rx_valid`, FSM in BREAK. Release the line and send 0x11 → delivered correctly.
5. Apply a 3000 ns low glitch on an idle line → no `rx_valid`, no error pulse, `rx_busy` drops within 1 bit.
6. Assert `resetn`=0 mid-byte, during bit 4 of 0x7E → all outputs go to 0 immediately. After release with the line idle, send 0x42 → delivered correctly. Repeat case 1 at bit periods of +3% and −3% → correct data.
